hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control consumer of the segment-register destination addresses: reads reg_dest from EX, MEM and WB and the source addresses from ID/EX.
- Drives the bubble/flush inputs of every segment register (IF..WB) and the EX operand forwarding selects.
- Adds a data-cache-miss stall FSM with handshake and two performance counters.
- Sits beside the five segment-register groups in the RV32I core.

Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- reg1_srcD, reg2_srcD  in  5  source register addresses in ID
- reg1_srcE, reg2_srcE  in  5  source register addresses in EX
- reg_dstE, reg_dstM, reg_dstW  in  5  destination register addresses in EX/MEM/WB
- reg_write_enM, reg_write_enW  in  1  register write enable of MEM/WB instruction
- mem_readE  in  1  EX instruction is a load
- br_takenE  in  1  branch taken, resolved in EX
- jalrE  in  1  jalr in EX
- jalD  in  1  jal in ID
- dcache_miss  in  1  data cache reports miss for the current MEM access
- dcache_ready  in  1  miss refill complete, data valid
- bubbleF, bubbleD, bubbleE, bubbleM, bubbleW  out  1  hold segment register
- flushF, flushD, flushE, flushM, flushW  out  1  clear segment register
- op1_sel, op2_sel  out  2  EX operand source: 00 regfile, 01 MEM result, 10 WB result
- miss_count  out  CNT_W  number of miss episodes
- stall_cycles  out  CNT_W  cycles spent in miss stall

Behaviour:
- FSM states are RUN and MISS. The state register and both counters are updated only on posedge clk.
- Reset (rst=1 at an edge): state goes to RUN and both counters go to 0.
- While rst=1, all flush outputs are 1, all bubble outputs are 0, and both selects are 00, regardless of other inputs. This applies to reset asserted mid-miss as well.
- stall_all is 1 when (state==RUN and dcache_miss and !dcache_ready) or (state==MISS and !dcache_ready).
- FSM transitions:
  - RUN to MISS on dcache_miss and !dcache_ready.
  - MISS to RUN on dcache_ready.
  - If dcache_miss and dcache_ready are both 1 in RUN, there is no stall and no transition.
- Counters:
  - miss_count increments on each RUN-to-MISS transition.
  - stall_cycles increments on each clk where stall_all is 1.
  - Both saturate at all-ones (no wrap).
- Forwarding (pure combinational, independent of stall), shown for op1 (op2 identical using reg2_srcE):
  - 01 if reg_write_enM and reg_dstM!=0 and reg_dstM==reg1_srcE;
  - else 10 if reg_write_enW and reg_dstW!=0 and reg_dstW==reg1_srcE;
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
- Control outputs, first matching rule wins:
  1. stall_all: all five bubble outputs are 1, all flush outputs are 0. Any pending branch, jal or load-use stays frozen and is handled after release.
  2. br_takenE or jalrE: flushD=1, flushE=1.
  3. Load-use: mem_readE and reg_dstE!=0 and (reg_dstE==reg1_srcD or reg_dstE==reg2_srcD). Outputs are bubbleF=1, bubbleD=1, flushE=1 for exactly one cycle. It resolves itself once the load moves to MEM.
  4. jalD: flushD=1.
  5. Otherwise every bubble and flush output is 0.
- Rule 2 overrides rule 3 in the same cycle; the mispredicted younger instruction is discarded.
- Release cycle (dcache_ready=1 in MISS): stall_all=0 in that same cycle, so the pipeline advances at that edge. Rules 2–4 apply normally in that cycle.
- No latency on control outputs: they are combinational from inputs and state.

Decomposition:
- Shared package holds:
  - FSM state encoding (RUN=0, MISS=1);
  - forwarding-select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
- One natural sub-module, fwd_sel: a combinational single-operand forwarding mux-select, instantiated twice (op1 and op2).
- FSM, counters and priority logic stay in hazard_ctrl.

Test Plan:
- Reset check: rst=1 for 2 cycles mid-MISS -> all flush outputs=1, selects=00, state=RUN, miss_count=0, stall_cycles=0 after release.
- Forwarding priority: reg_dstM=5 and reg_dstW=5 with both write enables=1, reg1_srcE=5 -> op1_sel=01. Clearing reg_write_enM -> op1_sel=10. With reg_dstM=0 and reg1_srcE=0 -> op1_sel=00.
- Load-use: mem_readE=1, reg_dstE=7, reg2_srcD=7 -> exactly one cycle of bubbleF=1, bubbleD=1, flushE=1; then all 0 once the load has moved to MEM.
- Branch vs load-use in the same cycle: br_takenE=1 with the load-use condition true -> flushD=1, flushE=1, bubbleF=0.
- Miss episode: dcache_miss=1 held, dcache_ready rises after 4 cycles -> all bubbles=1 for 4 cycles and 0 on the ready cycle; miss_count=1, stall_cycles=4. Repeated miss -> miss_count=2.
- Hit-in-same-cycle and saturation: dcache_miss=1 with dcache_ready=1 -> no stall and counters unchanged. Preload stall_cycles to all-ones (force) and stall -> value stays at all-ones.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// EX operand forwarding selects.
package hazard_ctrl_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX operand; MEM result wins over WB, x0 never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_e,
  input  logic [4:0] reg_dstM,
  input  logic [4:0] reg_dstW,
  input  logic       reg_write_enM,
  input  logic       reg_write_enW,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_enM && (reg_dstM != 5'd0) && (reg_dstM == src_e)) begin
      sel = FWD_MEM;
    end else if (reg_write_enW && (reg_dstW != 5'd0) && (reg_dstW == src_e)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// RV32I pipeline hazard controller: segment-register bubble/flush control,
// EX forwarding selects, data-cache miss stall FSM and performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       reg1_srcD,
  input  logic [4:0]       reg2_srcD,
  input  logic [4:0]       reg1_srcE,
  input  logic [4:0]       reg2_srcE,
  input  logic [4:0]       reg_dstE,
  input  logic [4:0]       reg_dstM,
  input  logic [4:0]       reg_dstW,
  input  logic             reg_write_enM,
  input  logic             reg_write_enW,
  input  logic             mem_readE,
  input  logic             br_takenE,
  input  logic             jalrE,
  input  logic             jalD,
  input  logic             dcache_miss,
  input  logic             dcache_ready,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       op1_sel,
  output logic [1:0]       op2_sel,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_all;
  logic             miss_start;
  logic             load_use;
  logic [1:0]       op1_fwd, op2_fwd;

  fwd_sel u_fwd_op1 (
    .src_e         (reg1_srcE),
    .reg_dstM      (reg_dstM),
    .reg_dstW      (reg_dstW),
    .reg_write_enM (reg_write_enM),
    .reg_write_enW (reg_write_enW),
    .sel           (op1_fwd)
  );

  fwd_sel u_fwd_op2 (
    .src_e         (reg2_srcE),
    .reg_dstM      (reg_dstM),
    .reg_dstW      (reg_dstW),
    .reg_write_enM (reg_write_enM),
    .reg_write_enW (reg_write_enW),
    .sel           (op2_fwd)
  );

  // A miss answered in the same cycle (miss && ready) is treated as a hit.
  assign miss_start = (state_q == ST_RUN) && dcache_miss && !dcache_ready;
  assign stall_all  = miss_start || ((state_q == ST_MISS) && !dcache_ready);
  assign load_use   = mem_readE && (reg_dstE != 5'd0) &&
                      ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));

  always_comb begin
    state_d = state_q;
    if (miss_start) begin
      state_d = ST_MISS;
    end else if ((state_q == ST_MISS) && dcache_ready) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    miss_cnt_d  = miss_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (miss_start && (miss_cnt_q != {CNT_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
    if (stall_all && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_cnt_q  <= miss_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Priority: reset, miss stall, redirect in EX, load-use, jal in ID.
  always_comb begin
    {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b00000;
    {flushF, flushD, flushE, flushM, flushW}      = 5'b00000;
    op1_sel = op1_fwd;
    op2_sel = op2_fwd;
    if (rst) begin
      {flushF, flushD, flushE, flushM, flushW} = 5'b11111;
      op1_sel = FWD_RF;
      op2_sel = FWD_RF;
    end else if (stall_all) begin
      {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b11111;
    end else if (br_takenE || jalrE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      flushE  = 1'b1;
    end else if (jalD) begin
      flushD = 1'b1;
    end
  end

  assign miss_count   = miss_cnt_q;
  assign stall_cycles = stall_cnt_q;

endmodule
